lfsr_rng: RTL and testbench

LFSR_RNG -- requirements
Module: lfsr_rng

---
 rtl/lfsr_rng.sv | 162 ++++++++++++++++
 tb/tb_lfsr_rng.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_rng.sv
// Fibonacci LFSR with a bounded rejection-sampling draw engine (IDLE/DRAW/CHECK/RESP).
// Optional macro LFSR_LOCKUP_RECOVER_EN replaces zero seeds and an all-zero state with SEED.
module lfsr_rng #(
    parameter int          WIDTH     = 16,
    parameter int          OUT_BITS  = 4,
    parameter logic [31:0] SEED      = 32'h0000ACE1,
    parameter int          MAX_TRIES = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                seed_load,
    input  logic [WIDTH-1:0]    seed_in,
    input  logic                req,
    input  logic [OUT_BITS-1:0] limit,
    output logic                busy,
    output logic                rsp_valid,
    output logic [OUT_BITS-1:0] rsp_value,
    output logic                rsp_fallback,
    output logic [WIDTH-1:0]    val
);

    typedef enum logic [1:0] {IDLE, DRAW, CHECK, RESP} state_t;

    // Tap masks are the 1-based tap lists shifted down to 0-based bit positions.
    localparam logic [31:0] TAPS32 = (WIDTH == 8)  ? 32'h000000B8 :
                                     (WIDTH == 16) ? 32'h0000B400 :
                                     (WIDTH == 24) ? 32'h00E10000 :
                                                     32'h80200003;
    localparam logic [WIDTH-1:0] TAP_MASK  = TAPS32[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED_W    = SEED[WIDTH-1:0];
    localparam logic [5:0]       LAST_STEP = 6'(OUT_BITS - 1);
    localparam logic [7:0]       MAX_T     = 8'(MAX_TRIES);

    state_t              state_reg, state_next;
    logic [WIDTH-1:0]    val_reg, val_next;
    logic [5:0]          step_reg, step_next;
    logic [7:0]          try_reg, try_next;
    logic [OUT_BITS-1:0] limit_reg, limit_next;
    logic [OUT_BITS-1:0] value_reg, value_next;
    logic                fallback_reg, fallback_next;

    logic [WIDTH-1:0]    tap_terms;
    logic [WIDTH-1:0]    stepped;
    logic [WIDTH-1:0]    seed_eff;
    logic [OUT_BITS-1:0] candidate;
    logic                fb;
    logic                accept;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_tap
        assign tap_terms[gi] = TAP_MASK[gi] & val_reg[gi];
    end

    assign fb        = ^tap_terms;
    assign stepped   = {val_reg[WIDTH-2:0], fb};
    assign candidate = val_reg[OUT_BITS-1:0];
    assign accept    = (limit_reg == '0) || (candidate < limit_reg);

`ifdef LFSR_LOCKUP_RECOVER_EN
    assign seed_eff = (seed_in == '0) ? SEED_W : seed_in;
`else
    assign seed_eff = seed_in;
`endif

    always_comb begin
        state_next    = state_reg;
        val_next      = val_reg;
        step_next     = step_reg;
        try_next      = try_reg;
        limit_next    = limit_reg;
        value_next    = value_reg;
        fallback_next = fallback_reg;

        case (state_reg)
            IDLE: begin
                if (enable) begin
                    val_next = stepped;
                end
                if (req) begin
                    state_next = DRAW;
                    limit_next = limit;
                    step_next  = '0;
                    try_next   = '0;
                end
            end
            DRAW: begin
                val_next = stepped;
                if (step_reg == LAST_STEP) begin
                    state_next = CHECK;
                    step_next  = '0;
                end else begin
                    step_next = step_reg + 6'd1;
                end
            end
            CHECK: begin
                if (accept) begin
                    state_next    = RESP;
                    value_next    = candidate;
                    fallback_next = 1'b0;
                end else if (try_reg < MAX_T - 8'd1) begin
                    state_next = DRAW;
                    try_next   = try_reg + 8'd1;
                end else begin
                    state_next    = RESP;
                    value_next    = '0;
                    fallback_next = 1'b1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A reload mid-request restarts the current attempt without consuming a try.
        if (seed_load) begin
            val_next = seed_eff;
            if ((state_reg == DRAW) || (state_reg == CHECK)) begin
                state_next    = DRAW;
                step_next     = '0;
                try_next      = try_reg;
                value_next    = value_reg;
                fallback_next = fallback_reg;
            end
        end

`ifdef LFSR_LOCKUP_RECOVER_EN
        if (!seed_load && (val_reg == '0)) begin
            val_next = SEED_W;
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            val_reg      <= SEED_W;
            step_reg     <= '0;
            try_reg      <= '0;
            limit_reg    <= '0;
            value_reg    <= '0;
            fallback_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            val_reg      <= val_next;
            step_reg     <= step_next;
            try_reg      <= try_next;
            limit_reg    <= limit_next;
            value_reg    <= value_next;
            fallback_reg <= fallback_next;
        end
    end

    assign busy         = (state_reg != IDLE);
    assign rsp_valid    = (state_reg == RESP);
    assign rsp_value    = value_reg;
    assign rsp_fallback = fallback_reg;
    assign val          = val_reg;

endmodule

// File: tb/tb_lfsr_rng.sv
// Directed bench for lfsr_rng (WIDTH=16, OUT_BITS=4, MAX_TRIES=2) with a response scoreboard.
module tb_lfsr_rng;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        seed_load;
    logic [15:0] seed_in;
    logic        req;
    logic [3:0]  limit;
    logic        busy;
    logic        rsp_valid;
    logic [3:0]  rsp_value;
    logic        rsp_fallback;
    logic [15:0] val;

    int          compared   = 0;
    int          mismatched = 0;
    int          pulses     = 0;
    logic [4:0]  exp_q[$];
    logic [4:0]  exp_head;
    logic [15:0] mv;

    lfsr_rng #(
        .WIDTH(16),
        .OUT_BITS(4),
        .SEED(32'h0000ACE1),
        .MAX_TRIES(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .seed_load(seed_load),
        .seed_in(seed_in),
        .req(req),
        .limit(limit),
        .busy(busy),
        .rsp_valid(rsp_valid),
        .rsp_value(rsp_value),
        .rsp_fallback(rsp_fallback),
        .val(val)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] step16(input logic [15:0] x);
`ifdef LFSR_LOCKUP_RECOVER_EN
        if (x == 16'h0000) return 16'hACE1;
`endif
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    // Reference draw: rejection sampling with at most 2 attempts.
    task automatic model_draw(input logic [15:0] v_in, input logic [3:0] lim,
                              output logic [3:0] ev, output logic ef,
                              output int bc, output logic [15:0] v_out);
        logic [15:0] v;
        bit          done;
        v    = v_in;
        done = 0;
        bc   = 0;
        ev   = 4'h0;
        ef   = 1'b1;
        for (int t = 0; t < 2; t++) begin
            if (!done) begin
                for (int s = 0; s < 4; s++) v = step16(v);
                bc += 5;
                if ((lim == 4'h0) || (v[3:0] < lim)) begin
                    ev   = v[3:0];
                    ef   = 1'b0;
                    done = 1;
                end
            end
        end
        bc += 1;
        v_out = v;
    endtask

    task automatic load_seed(input logic [15:0] s);
        seed_in   = s;
        seed_load = 1'b1;
        @(posedge clock); #1;
        seed_load = 1'b0;
`ifdef LFSR_LOCKUP_RECOVER_EN
        mv = (s == 16'h0000) ? 16'hACE1 : s;
`else
        mv = s;
`endif
        check("seed_load_val", {16'h0, val}, {16'h0, mv});
    endtask

    task automatic do_draw(input string tag, input logic [3:0] lim, input bit hold, input bit en,
                           input int reload, input logic [15:0] reload_seed);
        logic [3:0]  ev;
        logic        ef;
        int          exp_bc;
        logic [15:0] v_end;
        int          bc;
        int          vc;
        bit          done;
        model_draw((reload != 0) ? reload_seed : mv, lim, ev, ef, exp_bc, v_end);
        exp_bc += reload;
        exp_q.push_back({ef, ev});
        limit = lim;
        req   = 1'b1;
        @(posedge clock); #1;
        if (!hold) req = 1'b0;
        if (en) enable = 1'b1;
        bc   = 0;
        vc   = 0;
        done = 0;
        for (int c = 1; c <= 100; c++) begin
            if ((reload != 0) && (c == reload)) begin
                seed_load = 1'b1;
                seed_in   = reload_seed;
            end
            if ((reload != 0) && (c == reload + 1)) seed_load = 1'b0;
            if (!busy) begin
                done = 1;
                break;
            end
            bc++;
            if (rsp_valid) begin
                vc     = c;
                req    = 1'b0;
                enable = 1'b0;
            end
            @(posedge clock); #1;
        end
        req       = 1'b0;
        enable    = 1'b0;
        seed_load = 1'b0;
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy_cycles"}, bc, exp_bc);
        check({tag, "_valid_cycle"}, vc, exp_bc);
        check({tag, "_val_after"}, {16'h0, val}, {16'h0, v_end});
        mv = v_end;
    endtask

    always @(negedge clock) begin
        if (!reset && rsp_valid) begin
            pulses++;
            check("rsp_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                exp_head = exp_q.pop_front();
                check("rsp_result", {27'h0, rsp_fallback, rsp_value}, {27'h0, exp_head});
                $display("rsp #%0d: value=0x%0h fallback=%0b (expected value=0x%0h fallback=%0b)",
                         pulses, rsp_value, rsp_fallback, exp_head[3:0], exp_head[4]);
            end
        end
    end

    initial begin
        int first;
        int p0;
        reset     = 1'b1;
        enable    = 1'b0;
        seed_load = 1'b0;
        seed_in   = 16'h0;
        req       = 1'b0;
        limit     = 4'h0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_val", {16'h0, val}, 32'h0000ACE1);
        check("reset_busy", {31'h0, busy}, 32'd0);
        check("reset_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        check("reset_rsp_value", {28'h0, rsp_value}, 32'd0);
        check("reset_rsp_fallback", {31'h0, rsp_fallback}, 32'd0);

        // Free run: one step, then the full period.
        reset  = 1'b0;
        enable = 1'b1;
        @(posedge clock); #1;
        check("enable_one_step", {16'h0, val}, 32'h000059C3);
        first = 0;
        for (int n = 2; n <= 65535; n++) begin
            @(posedge clock); #1;
            if ((val == 16'hACE1) && (first == 0)) first = n;
        end
        enable = 1'b0;
        check("period_first_return", first, 65535);
        mv = 16'hACE1;

        // limit 0 from 0xACE1, enable held high while busy.
        do_draw("draw_limit0", 4'h0, 1'b0, 1'b1, 0, 16'h0);
        check("draw_limit0_value", {28'h0, rsp_value}, 32'h0000000E);

        // Two rejections exhaust MAX_TRIES; req held high throughout.
        load_seed(16'hACE1);
        do_draw("draw_fallback", 4'h1, 1'b1, 1'b0, 0, 16'h0);
        repeat (3) @(posedge clock);
        #1;
        check("hold_rsp_fallback", {31'h0, rsp_fallback}, 32'd1);
        check("hold_rsp_value", {28'h0, rsp_value}, 32'd0);

        load_seed(16'h0001);
        do_draw("draw_first_pass", 4'h1, 1'b1, 1'b0, 0, 16'h0);

        load_seed(16'h8000);
        do_draw("draw_one_retry", 4'h1, 1'b1, 1'b0, 0, 16'h0);

        // Reload mid-DRAW restarts the attempt from the new seed.
        load_seed(16'hACE1);
        do_draw("draw_reload", 4'h0, 1'b0, 1'b0, 3, 16'h8000);
        check("draw_reload_value", {28'h0, rsp_value}, 32'h00000008);

        // Zero seed: lockup without the recovery macro, SEED with it.
        load_seed(16'h0000);
        do_draw("draw_zero_seed", 4'h5, 1'b0, 1'b0, 0, 16'h0);

        // Reset in the middle of DRAW abandons the request.
        p0    = pulses;
        limit = 4'h0;
        req   = 1'b1;
        @(posedge clock); #1;
        req = 1'b0;
        @(posedge clock); #1;
        check("midreset_busy_before", {31'h0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("midreset_busy", {31'h0, busy}, 32'd0);
        check("midreset_val", {16'h0, val}, 32'h0000ACE1);
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (12) @(posedge clock);
        #1;
        check("midreset_no_pulse", pulses, p0);
        check("midreset_idle", {31'h0, busy}, 32'd0);
        check("midreset_val_after", {16'h0, val}, 32'h0000ACE1);

        check("pulse_count", pulses, 6);
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
